segment_mem_ctrl: RTL and testbench

- Access controller (initiator side) for one segment of the segment buffer/stage-output memory.
- Owns circular-buffer write/read pointers, occupancy and full/empty state for one segment.
- Generates the advanced (one cycle early) addresses, enables and address-match flags the segment memory consumes.
- Drives the output-register enable and marks when read data is valid at the memory's registered output.

---
 rtl/segment_ctrl_pkg.sv | 25 ++
 rtl/seg_ptr_ctr.sv | 27 ++
 rtl/segment_mem_ctrl.sv | 104 ++++++++++
 tb/tb_segment_mem_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/segment_ctrl_pkg.sv
// Shared definitions for the segment memory access controllers:
// address-width helper, default depth and the occupancy/status bundle.
package segment_ctrl_pkg;

  localparam int DEFAULT_NUM_WORDS = 16;
  localparam int STATUS_CNT_W      = 16;

  function automatic int seg_clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // Count is carried at a fixed width so segment-level wrappers can aggregate
  // status from segments of differing depth.
  typedef struct packed {
    logic [STATUS_CNT_W-1:0] count;
    logic                    full;
    logic                    empty;
    logic                    overflow_err;
    logic                    underflow_err;
  } seg_status_t;

endpackage

// File: rtl/seg_ptr_ctr.sv
// Circular-buffer pointer that wraps at NUM_WORDS-1, so the depth need not be
// a power of two.
module seg_ptr_ctr
  import segment_ctrl_pkg::*;
#(
  parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
  parameter int BITS_ADDR = seg_clog2(NUM_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [BITS_ADDR-1:0] ptr
);

  logic [BITS_ADDR-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= (r_ptr == BITS_ADDR'(NUM_WORDS - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/segment_mem_ctrl.sv
// Initiator-side access controller for one segment of the segment buffer:
// pointers, occupancy, advanced memory controls and read-data pipeline flags.
module segment_mem_ctrl
  import segment_ctrl_pkg::*;
#(
  parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
  parameter int BITS_ADDR = seg_clog2(NUM_WORDS),
  parameter int BITS_CNT  = BITS_ADDR + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  output logic                 wr_en_adv,
  output logic [BITS_ADDR-1:0] adv_wr_addr,
  output logic                 rd_en_adv,
  output logic [BITS_ADDR-1:0] adv_rd_addr,
  output logic                 adv_rd_wr_addr_match_flag,
  output logic                 rd_wr_addr_match_flag,
  output logic                 out_reg_en,
  output logic                 dout_valid,
  output logic                 full,
  output logic                 empty,
  output logic [BITS_CNT-1:0]  count,
  output logic                 overflow_err,
  output logic                 underflow_err
);

  logic [BITS_CNT-1:0]  r_count;
  logic                 r_match_d;
  logic                 r_out_reg_en;
  logic                 r_dout_valid;
  logic                 r_overflow_err;
  logic                 r_underflow_err;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push_acc;
  logic                 w_pop_acc;
  logic [BITS_ADDR-1:0] w_wr_ptr;
  logic [BITS_ADDR-1:0] w_rd_ptr;
  seg_status_t          w_status;

  assign w_full     = (r_count == BITS_CNT'(NUM_WORDS));
  assign w_empty    = (r_count == '0);
  assign w_push_acc = push && !w_full;
  // An empty segment can still serve a pop when the same-cycle push flows through.
  assign w_pop_acc  = pop && (!w_empty || w_push_acc);

  seg_ptr_ctr #(.NUM_WORDS(NUM_WORDS), .BITS_ADDR(BITS_ADDR)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_push_acc),
    .ptr (w_wr_ptr)
  );

  seg_ptr_ctr #(.NUM_WORDS(NUM_WORDS), .BITS_ADDR(BITS_ADDR)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_pop_acc),
    .ptr (w_rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count         <= '0;
      r_match_d       <= 1'b0;
      r_out_reg_en    <= 1'b0;
      r_dout_valid    <= 1'b0;
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      if (w_push_acc && !w_pop_acc)      r_count <= r_count + 1'b1;
      else if (w_pop_acc && !w_push_acc) r_count <= r_count - 1'b1;
      r_match_d    <= adv_rd_wr_addr_match_flag;
      r_out_reg_en <= w_pop_acc;
      r_dout_valid <= r_out_reg_en;
      if (push && w_full)            r_overflow_err  <= 1'b1;
      if (pop && w_empty && !push)   r_underflow_err <= 1'b1;
    end
  end

  assign w_status.count         = STATUS_CNT_W'(r_count);
  assign w_status.full          = w_full;
  assign w_status.empty         = w_empty;
  assign w_status.overflow_err  = r_overflow_err;
  assign w_status.underflow_err = r_underflow_err;

  assign wr_en_adv                 = w_push_acc;
  assign adv_wr_addr               = w_wr_ptr;
  assign rd_en_adv                 = w_pop_acc;
  assign adv_rd_addr               = w_rd_ptr;
  // Only reachable when empty: otherwise the pointers differ or full blocks the push.
  assign adv_rd_wr_addr_match_flag = w_push_acc && w_pop_acc && w_empty;
  assign rd_wr_addr_match_flag     = r_match_d;
  assign out_reg_en                = r_out_reg_en;
  assign dout_valid                = r_dout_valid;
  assign full                      = w_status.full;
  assign empty                     = w_status.empty;
  assign count                     = w_status.count[BITS_CNT-1:0];
  assign overflow_err              = w_status.overflow_err;
  assign underflow_err             = w_status.underflow_err;

endmodule

// File: tb/tb_segment_mem_ctrl.sv
// Directed-vector bench for segment_mem_ctrl with an 8-word segment;
// expected values are hand-derived from the access and pipeline rules.
module tb_segment_mem_ctrl;

  localparam int NW = 8;
  localparam int BA = 3;
  localparam int BC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          wr_en_adv;
  logic [BA-1:0] adv_wr_addr;
  logic          rd_en_adv;
  logic [BA-1:0] adv_rd_addr;
  logic          adv_rd_wr_addr_match_flag;
  logic          rd_wr_addr_match_flag;
  logic          out_reg_en;
  logic          dout_valid;
  logic          full;
  logic          empty;
  logic [BC-1:0] count;
  logic          overflow_err;
  logic          underflow_err;

  int n_vec = 0;
  int n_bad = 0;

  segment_mem_ctrl #(.NUM_WORDS(NW), .BITS_ADDR(BA), .BITS_CNT(BC)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .push                      (push),
    .pop                       (pop),
    .wr_en_adv                 (wr_en_adv),
    .adv_wr_addr               (adv_wr_addr),
    .rd_en_adv                 (rd_en_adv),
    .adv_rd_addr               (adv_rd_addr),
    .adv_rd_wr_addr_match_flag (adv_rd_wr_addr_match_flag),
    .rd_wr_addr_match_flag     (rd_wr_addr_match_flag),
    .out_reg_en                (out_reg_en),
    .dout_valid                (dout_valid),
    .full                      (full),
    .empty                     (empty),
    .count                     (count),
    .overflow_err              (overflow_err),
    .underflow_err             (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic p, input logic q);
    @(negedge clk);
    push = p;
    pop  = q;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    push = 1'b0;
    pop  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    do_reset();
    check_vec("rst count", count, 0);
    check_vec("rst empty", empty, 1);
    check_vec("rst full", full, 0);
    check_vec("rst out_reg_en", out_reg_en, 0);
    check_vec("rst dout_valid", dout_valid, 0);
    check_vec("rst match_d", rd_wr_addr_match_flag, 0);
    check_vec("rst errs", {overflow_err, underflow_err}, 0);

    // Fill then drain.
    for (int i = 0; i < NW; i++) begin
      drive(1, 0);
      check_vec($sformatf("fill wr_en %0d", i), wr_en_adv, 1);
      check_vec($sformatf("fill wr_addr %0d", i), adv_wr_addr, i);
    end
    drive(0, 0);
    check_vec("fill full", full, 1);
    check_vec("fill count", count, 8);
    for (int i = 0; i < NW; i++) begin
      drive(0, 1);
      check_vec($sformatf("drain rd_en %0d", i), rd_en_adv, 1);
      check_vec($sformatf("drain rd_addr %0d", i), adv_rd_addr, i);
      check_vec($sformatf("drain out_reg_en %0d", i), out_reg_en, (i >= 1) ? 1 : 0);
      check_vec($sformatf("drain dout_valid %0d", i), dout_valid, (i >= 2) ? 1 : 0);
    end
    drive(0, 0);
    check_vec("drain tail out_reg_en", out_reg_en, 1);
    check_vec("drain tail dout_valid a", dout_valid, 1);
    drive(0, 0);
    check_vec("drain tail out_reg_en off", out_reg_en, 0);
    check_vec("drain tail dout_valid b", dout_valid, 1);
    drive(0, 0);
    check_vec("drain dout_valid off", dout_valid, 0);
    check_vec("drain empty", empty, 1);
    check_vec("drain errs", {overflow_err, underflow_err}, 0);

    // Flow-through on empty; pointers have wrapped back to 0.
    drive(1, 1);
    check_vec("flow adv_match", adv_rd_wr_addr_match_flag, 1);
    check_vec("flow rd_en", rd_en_adv, 1);
    check_vec("flow wr_en", wr_en_adv, 1);
    check_vec("flow addrs", {adv_wr_addr, adv_rd_addr}, 0);
    drive(0, 0);
    check_vec("flow match_d", rd_wr_addr_match_flag, 1);
    check_vec("flow out_reg_en", out_reg_en, 1);
    check_vec("flow count", count, 0);
    check_vec("flow adv_match clear", adv_rd_wr_addr_match_flag, 0);
    drive(0, 0);
    check_vec("flow dout_valid", dout_valid, 1);
    check_vec("flow match_d clear", rd_wr_addr_match_flag, 0);

    // Wrap: 6 pushes, 6 pops, 4 pushes, 4 pops.
    do_reset();
    for (int i = 0; i < 6; i++) drive(1, 0);
    for (int i = 0; i < 6; i++) drive(0, 1);
    begin
      int exp_addr [4] = '{6, 7, 0, 1};
      for (int i = 0; i < 4; i++) begin
        drive(1, 0);
        check_vec($sformatf("wrap wr_addr %0d", i), adv_wr_addr, exp_addr[i]);
      end
      drive(0, 0);
      check_vec("wrap count", count, 4);
      for (int i = 0; i < 4; i++) begin
        drive(0, 1);
        check_vec($sformatf("wrap rd_addr %0d", i), adv_rd_addr, exp_addr[i]);
        check_vec($sformatf("wrap adv_match %0d", i), adv_rd_wr_addr_match_flag, 0);
      end
      drive(0, 0);
      check_vec("wrap empty", empty, 1);
    end

    // Overflow: full with push+pop.
    do_reset();
    for (int i = 0; i < NW; i++) drive(1, 0);
    drive(1, 1);
    check_vec("ovf wr_en", wr_en_adv, 0);
    check_vec("ovf rd_en", rd_en_adv, 1);
    drive(0, 0);
    check_vec("ovf flag", overflow_err, 1);
    check_vec("ovf count", count, 7);
    check_vec("ovf no underflow", underflow_err, 0);
    drive(0, 0);
    check_vec("ovf sticky", overflow_err, 1);

    // Underflow: pop alone on empty.
    do_reset();
    drive(0, 1);
    check_vec("unf rd_en", rd_en_adv, 0);
    drive(0, 0);
    check_vec("unf out_reg_en", out_reg_en, 0);
    check_vec("unf flag", underflow_err, 1);
    check_vec("unf count", count, 0);
    drive(0, 0);
    check_vec("unf dout_valid", dout_valid, 0);
    check_vec("unf sticky", underflow_err, 1);

    // Reset mid-stream abandons the in-flight read.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 0);
    drive(0, 0);
    check_vec("mid count5", count, 5);
    drive(0, 1);
    @(negedge clk);
    rst  = 1'b1;
    pop  = 1'b0;
    #1;
    check_vec("mid out_reg_en pre", out_reg_en, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_vec("mid dout_valid", dout_valid, 0);
    check_vec("mid count", count, 0);
    check_vec("mid ptrs", {adv_wr_addr, adv_rd_addr}, 0);
    check_vec("mid errs", {overflow_err, underflow_err}, 0);
    drive(1, 1);
    check_vec("mid post dout_valid", dout_valid, 0);
    check_vec("mid post wr_addr", adv_wr_addr, 0);
    check_vec("mid post rd_addr", adv_rd_addr, 0);
    check_vec("mid post match", adv_rd_wr_addr_match_flag, 1);
    drive(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
